// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: locks to vsync, checks line/frame periods, sync widths and blanking, counts frames.
// Latency: inputs registered once; flags and counters update one cycle after the edge is seen.
// Passive observer with no backpressure. Frame CRC-32 over active pixels only when VGA_MON_CRC_EN is defined.
module vga_timing_monitor #(
  parameter int H_TOTAL    = 1040,
  parameter int H_SYNC     = 120,
  parameter int H_BACK     = 64,
  parameter int H_ACTIVE   = 800,
  parameter int V_TOTAL    = 666,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 23,
  parameter int V_ACTIVE   = 600,
  parameter bit SYNC_POL   = 1'b1,
  parameter int COLOR_BITS = 1
) (
  input  logic                  clk,
  input  logic                  n_rst_async,
  input  logic [COLOR_BITS-1:0] vga_r,
  input  logic [COLOR_BITS-1:0] vga_g,
  input  logic [COLOR_BITS-1:0] vga_b,
  input  logic                  vga_hsync,
  input  logic                  vga_vsync,
  output logic                  locked,
  output logic [31:0]           frame_count,
  output logic                  err_htiming,
  output logic                  err_vtiming,
  output logic                  err_blank,
  output logic [31:0]           frame_crc,
  output logic                  crc_valid
);

  localparam int          PW          = 3 * COLOR_BITS;
  localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_SYNC_LAST = 16'(H_SYNC - 1);
  localparam logic [15:0] HA_LO       = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] HA_HI       = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_SYNC_W    = 12'(V_SYNC);
  localparam logic [11:0] VA_LO       = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA_HI       = 12'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic {SEEK, LOCKED} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] pix_q;
  logic          hs_q, vs_q, hs_prev, vs_prev;
  logic          hs_rise, hs_fall, vs_rise, vs_fall;
  logic [15:0]   hcnt;
  logic [11:0]   vcnt;
  logic          hcnt_sat, vcnt_sat;
  logic          h_arm, v_arm, in_lock, in_active;
  logic          h_bad, v_bad, blank_bad;

  // Syncs are normalised to active-high at the input register.
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      pix_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      pix_q   <= {vga_r, vga_g, vga_b};
      hs_q    <= vga_hsync ^ ~SYNC_POL;
      vs_q    <= vga_vsync ^ ~SYNC_POL;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
    end
  end

  assign hs_rise  = hs_q & ~hs_prev;
  assign hs_fall  = ~hs_q & hs_prev;
  assign vs_rise  = vs_q & ~vs_prev;
  assign vs_fall  = ~vs_q & vs_prev;
  assign hcnt_sat = &hcnt;
  assign vcnt_sat = &vcnt;
  assign in_lock  = (state == LOCKED);
  assign locked   = in_lock;

  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) state <= SEEK;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEEK:    if (vs_rise) state_nxt = LOCKED;
      default: state_nxt = LOCKED;
    endcase
  end

  // vsync restarts the line count even when hsync rises in the same cycle.
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (hs_rise)        hcnt <= '0;
      else if (!hcnt_sat) hcnt <= hcnt + 16'd1;
      if (vs_rise)                   vcnt <= '0;
      else if (hs_rise && !vcnt_sat) vcnt <= vcnt + 12'd1;
    end
  end

  always_comb begin
    h_bad     = 1'b0;
    v_bad     = 1'b0;
    blank_bad = 1'b0;
    in_active = (hcnt >= HA_LO) && (hcnt < HA_HI) && (vcnt >= VA_LO) && (vcnt < VA_HI);
    if (in_lock && h_arm)
      h_bad = (hs_rise && hcnt != H_LAST) || (hs_fall && hcnt != H_SYNC_LAST) || hcnt_sat;
    if (in_lock && v_arm)
      v_bad = (vs_rise && vcnt != V_LAST) || (vs_fall && vcnt != V_SYNC_W) || vcnt_sat;
    if (v_arm && !in_active)
      blank_bad = |pix_q;
  end

  // First line and frame after lock are partial, so each check arms on its first edge in LOCKED.
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      h_arm       <= 1'b0;
      v_arm       <= 1'b0;
      frame_count <= '0;
      err_htiming <= 1'b0;
      err_vtiming <= 1'b0;
      err_blank   <= 1'b0;
    end else begin
      if (in_lock && hs_rise) h_arm <= 1'b1;
      if (in_lock && vs_rise) begin
        v_arm       <= 1'b1;
        frame_count <= frame_count + 32'd1;
      end
      if (h_bad)     err_htiming <= 1'b1;
      if (v_bad)     err_vtiming <= 1'b1;
      if (blank_bad) err_blank   <= 1'b1;
    end
  end

`ifdef VGA_MON_CRC_EN
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PW-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = PW - 1; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  logic [31:0] crc_acc;

  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      crc_acc   <= 32'hFFFF_FFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (vs_rise) begin
        crc_acc <= 32'hFFFF_FFFF;
        if (v_arm) begin
          frame_crc <= ~crc_acc;
          crc_valid <= 1'b1;
        end
      end else if (in_active) begin
        crc_acc <= crc_step(crc_acc, pix_q);
      end
    end
  end
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a shrunk 40x20 timing with active-low syncs.
module tb_vga_timing_monitor;

  localparam int HT = 40, HS = 4, HB = 3, HA = 24;
  localparam int VT = 20, VS = 2, VB = 3, VA = 12;
  localparam bit POL = 1'b0;

  logic        clk = 1'b0;
  logic        n_rst_async;
  logic        vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync;
  logic        locked;
  logic [31:0] frame_count;
  logic        err_htiming, err_vtiming, err_blank;
  logic [31:0] frame_crc;
  logic        crc_valid;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          crc_pulses = 0;
  logic [31:0] crc_last = '0;
  logic [31:0] crc_prev = '0;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .SYNC_POL(POL), .COLOR_BITS(1)
  ) dut (
    .clk(clk), .n_rst_async(n_rst_async),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .locked(locked), .frame_count(frame_count),
    .err_htiming(err_htiming), .err_vtiming(err_vtiming), .err_blank(err_blank),
    .frame_crc(frame_crc), .crc_valid(crc_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (crc_valid === 1'b1) begin
      crc_pulses++;
      crc_prev = crc_last;
      crc_last = frame_crc;
    end
  end

  // vsync rises with hsync on line 0 and drops with hsync on line vs_w.
  // A red pixel meant for monitor hcnt h is driven at line position h+1 (input register lag).
  task automatic send_lines(input int y0, input int y1, input int vs_w,
                            input int short_y, input int px_y, input int px_h);
    for (int y = y0; y < y1; y++) begin
      int len;
      len = (y == short_y) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        logic hs, vs;
        hs = (p < HS);
        vs = (y < vs_w) || (y == vs_w && p < HS);
        vga_hsync = hs ^ ~POL;
        vga_vsync = vs ^ ~POL;
        vga_r = (y == px_y && p == px_h + 1) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int n_lines, input int vs_w, input int short_y,
                            input int px_y, input int px_h);
    send_lines(0, n_lines, vs_w, short_y, px_y, px_h);
  endtask

  task automatic ideal_frame();
    send_frame(VT, VS, -1, -1, 0);
  endtask

  task automatic pulse_reset();
    n_rst_async = 1'b0;
    @(posedge clk);
    #1;
    n_rst_async = 1'b1;
  endtask

  task automatic test_reset();
    n_rst_async = 1'b0;
    vga_r = 1'b0; vga_g = 1'b0; vga_b = 1'b0;
    vga_hsync = ~POL;
    vga_vsync = ~POL;
    #12;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    n_cmp++; if (frame_count !== 32'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (err_htiming !== 1'b0) begin n_bad++; $display("FAIL reset_err_htiming: got %0b want 0", err_htiming); end
    n_cmp++; if (err_vtiming !== 1'b0) begin n_bad++; $display("FAIL reset_err_vtiming: got %0b want 0", err_vtiming); end
    n_cmp++; if (err_blank !== 1'b0) begin n_bad++; $display("FAIL reset_err_blank: got %0b want 0", err_blank); end
    n_cmp++; if (frame_crc !== 32'd0 || crc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_crc: got %h/%0b want 0/0", frame_crc, crc_valid); end
    @(posedge clk);
    #1;
    n_rst_async = 1'b1;
  endtask

  task automatic test_ideal_stream();
    ideal_frame();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ideal_locked: got %0b want 1", locked); end
    n_cmp++; if (frame_count !== 32'd0) begin n_bad++; $display("FAIL ideal_fc0: got %0d want 0", frame_count); end
    ideal_frame();
    n_cmp++; if (frame_count !== 32'd1) begin n_bad++; $display("FAIL ideal_fc1: got %0d want 1", frame_count); end
    ideal_frame();
    n_cmp++; if (frame_count !== 32'd2) begin n_bad++; $display("FAIL ideal_fc2: got %0d want 2", frame_count); end
    n_cmp++; if (err_htiming !== 1'b0) begin n_bad++; $display("FAIL ideal_err_h: got %0b want 0", err_htiming); end
    n_cmp++; if (err_vtiming !== 1'b0) begin n_bad++; $display("FAIL ideal_err_v: got %0b want 0", err_vtiming); end
    n_cmp++; if (err_blank !== 1'b0) begin n_bad++; $display("FAIL ideal_err_blank: got %0b want 0", err_blank); end
  endtask

  task automatic test_short_line();
    send_frame(VT, VS, 8, -1, 0);
    n_cmp++; if (err_htiming !== 1'b1) begin n_bad++; $display("FAIL short_line_err_h: got %0b want 1", err_htiming); end
    n_cmp++; if (err_vtiming !== 1'b0) begin n_bad++; $display("FAIL short_line_err_v: got %0b want 0", err_vtiming); end
    ideal_frame();
    n_cmp++; if (err_htiming !== 1'b1) begin n_bad++; $display("FAIL short_line_sticky: got %0b want 1", err_htiming); end
    n_cmp++; if (err_vtiming !== 1'b0) begin n_bad++; $display("FAIL short_line_err_v_next: got %0b want 0", err_vtiming); end
    n_cmp++; if (frame_count !== 32'd4) begin n_bad++; $display("FAIL short_line_fc: got %0d want 4", frame_count); end
  endtask

  task automatic test_reset_midframe();
    send_lines(0, 10, VS, -1, -1, 0);
    n_cmp++; if (frame_count !== 32'd5) begin n_bad++; $display("FAIL mid_pre_fc: got %0d want 5", frame_count); end
    #2;
    n_rst_async = 1'b0;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_async_locked: got %0b want 0", locked); end
    n_cmp++; if (frame_count !== 32'd0) begin n_bad++; $display("FAIL mid_async_fc: got %0d want 0", frame_count); end
    n_cmp++; if (err_htiming !== 1'b0) begin n_bad++; $display("FAIL mid_async_err_h: got %0b want 0", err_htiming); end
    @(posedge clk);
    #1;
    n_rst_async = 1'b1;
    send_lines(10, VT, VS, -1, -1, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_partial_locked: got %0b want 0", locked); end
    n_cmp++; if ({err_htiming, err_vtiming, err_blank} !== 3'b000) begin n_bad++; $display("FAIL mid_partial_errs: got %b want 000", {err_htiming, err_vtiming, err_blank}); end
    ideal_frame();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL mid_relock: got %0b want 1", locked); end
    n_cmp++; if (frame_count !== 32'd0) begin n_bad++; $display("FAIL mid_relock_fc: got %0d want 0", frame_count); end
    ideal_frame();
    n_cmp++; if (frame_count !== 32'd1) begin n_bad++; $display("FAIL mid_relock_fc1: got %0d want 1", frame_count); end
    n_cmp++; if ({err_htiming, err_vtiming, err_blank} !== 3'b000) begin n_bad++; $display("FAIL mid_relock_errs: got %b want 000", {err_htiming, err_vtiming, err_blank}); end
  endtask

  task automatic test_short_frame();
    send_frame(VT - 1, VS, -1, -1, 0);
    n_cmp++; if (err_vtiming !== 1'b0) begin n_bad++; $display("FAIL short_frame_early: got %0b want 0", err_vtiming); end
    ideal_frame();
    n_cmp++; if (err_vtiming !== 1'b1) begin n_bad++; $display("FAIL short_frame_err_v: got %0b want 1", err_vtiming); end
    n_cmp++; if (err_htiming !== 1'b0) begin n_bad++; $display("FAIL short_frame_err_h: got %0b want 0", err_htiming); end
  endtask

  task automatic test_vsync_width();
    pulse_reset();
    ideal_frame();
    ideal_frame();
    send_frame(VT, VS - 1, -1, -1, 0);
    n_cmp++; if (err_vtiming !== 1'b1) begin n_bad++; $display("FAIL vwidth_err_v: got %0b want 1", err_vtiming); end
    n_cmp++; if (err_htiming !== 1'b0) begin n_bad++; $display("FAIL vwidth_err_h: got %0b want 0", err_htiming); end
    n_cmp++; if (err_blank !== 1'b0) begin n_bad++; $display("FAIL vwidth_err_blank: got %0b want 0", err_blank); end
  endtask

  task automatic test_blank();
    pulse_reset();
    send_frame(VT, VS, -1, 8, HS - 1);
    n_cmp++; if (err_blank !== 1'b0) begin n_bad++; $display("FAIL blank_unarmed: got %0b want 0", err_blank); end
    ideal_frame();
    send_frame(VT, VS, -1, 8, HS + HB);
    n_cmp++; if (err_blank !== 1'b0) begin n_bad++; $display("FAIL blank_first_px: got %0b want 0", err_blank); end
    send_frame(VT, VS, -1, VS + VB + VA - 1, HS + HB + HA - 1);
    n_cmp++; if (err_blank !== 1'b0) begin n_bad++; $display("FAIL blank_last_px: got %0b want 0", err_blank); end
    send_frame(VT, VS, -1, 8, HS + HB - 1);
    n_cmp++; if (err_blank !== 1'b1) begin n_bad++; $display("FAIL blank_back_porch: got %0b want 1", err_blank); end
    pulse_reset();
    ideal_frame();
    ideal_frame();
    send_frame(VT, VS, -1, VS + VB + VA, 10);
    n_cmp++; if (err_blank !== 1'b1) begin n_bad++; $display("FAIL blank_below: got %0b want 1", err_blank); end
    n_cmp++; if ({err_htiming, err_vtiming} !== 2'b00) begin n_bad++; $display("FAIL blank_below_timing: got %b want 00", {err_htiming, err_vtiming}); end
    pulse_reset();
    ideal_frame();
    ideal_frame();
    send_frame(VT, VS, -1, 8, HS + HB + HA);
    n_cmp++; if (err_blank !== 1'b1) begin n_bad++; $display("FAIL blank_right: got %0b want 1", err_blank); end
  endtask

  task automatic test_crc();
    int base;
    pulse_reset();
    base = crc_pulses;
    ideal_frame();
    ideal_frame();
    ideal_frame();
    ideal_frame();
`ifdef VGA_MON_CRC_EN
    n_cmp++; if (crc_pulses - base !== 2) begin n_bad++; $display("FAIL crc_pulses: got %0d want 2", crc_pulses - base); end
    n_cmp++; if (crc_prev !== crc_last) begin n_bad++; $display("FAIL crc_equal: got %h want %h", crc_last, crc_prev); end
`else
    n_cmp++; if (crc_pulses !== 0) begin n_bad++; $display("FAIL crc_pulses_off: got %0d want 0 (base %0d)", crc_pulses, base); end
    n_cmp++; if (frame_crc !== 32'd0) begin n_bad++; $display("FAIL crc_tied_off: got %h want 0", frame_crc); end
`endif
  endtask

  initial begin
    test_reset();
    test_ideal_stream();
    test_short_line();
    test_reset_midframe();
    test_short_frame();
    test_vsync_width();
    test_blank();
    test_crc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
